// File: rtl/risc16_pkg.sv
// Shared RISC16 instruction-format constants: field widths, field positions and key opcodes.
package risc16_pkg;

  localparam int unsigned OPW    = 4;
  localparam int unsigned RW     = 4;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned IW_DEF = 24;

  // Bit positions within a default-width (IW_DEF) instruction word.
  localparam int unsigned OP_MSB = IW_DEF - 1;
  localparam int unsigned RZ_MSB = OP_MSB - OPW;
  localparam int unsigned RX_MSB = IMM_W - 1;
  localparam int unsigned RY_MSB = RX_MSB - RW;

  localparam logic [OPW-1:0] OP_ADD     = 4'h1;
  localparam logic [OPW-1:0] OP_MVI     = 4'hC;
  localparam logic [OPW-1:0] OP_LOAD    = 4'hD;
  localparam logic [OPW-1:0] IMM_OP_MIN = 4'hC;

endpackage

// File: rtl/instr_field_split.sv
// Purely combinational split of an instruction word into opcode, register and immediate fields.
module instr_field_split #(
  parameter int unsigned     IW         = 24,
  parameter int unsigned     OPW        = risc16_pkg::OPW,
  parameter int unsigned     RW         = risc16_pkg::RW,
  parameter logic [OPW-1:0]  IMM_OP_MIN = risc16_pkg::IMM_OP_MIN
) (
  input  logic [IW-1:0]                 word,
  output logic [OPW-1:0]                opcode,
  output logic [RW-1:0]                 addr_rz,
  output logic [risc16_pkg::IMM_W-1:0]  src_imm,
  output logic [RW-1:0]                 addr_rx,
  output logic [RW-1:0]                 addr_ry,
  output logic                          is_imm
);

  assign opcode  = word[IW-1 -: OPW];
  assign addr_rz = word[IW-OPW-1 -: RW];
  assign src_imm = word[risc16_pkg::IMM_W-1:0];
  // Source registers overlay the top of the immediate field.
  assign addr_rx = src_imm[risc16_pkg::RX_MSB -: RW];
  assign addr_ry = src_imm[risc16_pkg::RY_MSB -: RW];
  assign is_imm  = (opcode >= IMM_OP_MIN);

endmodule

// File: rtl/instr_prefetch_reg.sv
// Prefetch queue of DEPTH instruction words with valid/ready on both sides and flush on branch;
// the head entry is presented as decoded fields.
module instr_prefetch_reg #(
  parameter int unsigned    IW         = 24,
  parameter int unsigned    OPW        = risc16_pkg::OPW,
  parameter int unsigned    RW         = risc16_pkg::RW,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [OPW-1:0] IMM_OP_MIN = risc16_pkg::IMM_OP_MIN
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [IW-1:0]                 instr_in,
  input  logic                          fetch_valid,
  output logic                          fetch_ready,
  input  logic                          flush,
  input  logic                          dec_ready,
  output logic                          dec_valid,
  output logic [OPW-1:0]                opcode,
  output logic [RW-1:0]                 addr_Rz,
  output logic [risc16_pkg::IMM_W-1:0]  src_imm,
  output logic [RW-1:0]                 addr_Rx,
  output logic [RW-1:0]                 addr_Ry,
  output logic                          is_imm,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [IW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;
  logic [IW-1:0] head_word;

  // No full-bypass: a pop in the same cycle does not make room for a push.
  assign fetch_ready = (count_q < CW'(DEPTH));
  assign dec_valid   = (count_q != '0);
  assign push        = fetch_valid && fetch_ready;
  assign pop         = dec_valid && dec_ready;
  assign count       = count_q;

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q] <= instr_in;
          wr_ptr_q        <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
      end
    end
  end

  // Blank the head when empty so stale storage never reaches the decoder.
  assign head_word = dec_valid ? mem_q[rd_ptr_q] : '0;

  instr_field_split #(
    .IW         (IW),
    .OPW        (OPW),
    .RW         (RW),
    .IMM_OP_MIN (IMM_OP_MIN)
  ) u_field_split (
    .word    (head_word),
    .opcode  (opcode),
    .addr_rz (addr_Rz),
    .src_imm (src_imm),
    .addr_rx (addr_Rx),
    .addr_ry (addr_Ry),
    .is_imm  (is_imm)
  );

endmodule
